// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector engine sequencer.
// Holds the FSM state type, the node result-slice position and array size defaults.
package mv_pkg;

    localparam int N_ROWS_DFLT  = 16;
    localparam int MAX_LEN_DFLT = 256;
    localparam int RES_MSB      = 40;
    localparam int RES_LSB      = 17;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/mv_ctl_delay.sv
// Control shift register that carries {ce,csel} from the buffer read strobe
// to the node input stage, so the controls arrive together with the data.
module mv_ctl_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    // NOTE: this pipeline is reset and flushable, unlike a data RAM, because a stale ce bit would fire the nodes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mv_seq_ctrl.sv
// Sequencer for the matrix-vector node array: clears the nodes, streams len
// buffer columns, drains the MAC pipeline and walks the result mux row by row.
module mv_seq_ctrl
    import mv_pkg::*;
#(
    parameter int N_ROWS  = N_ROWS_DFLT,
    parameter int MAX_LEN = MAX_LEN_DFLT,
    parameter int LEN_W   = 9,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic                      cfg_sub,
    output logic                      busy,
    output logic                      done,
    output logic                      buf_rd_en,
    output logic [LEN_W-2:0]          buf_addr,
    output logic                      node_ce,
    output logic                      node_sclr,
    output logic                      node_csel,
    output logic                      node_sub,
    output logic [$clog2(N_ROWS)-1:0] res_sel,
    output logic                      res_valid
);

    localparam int SEL_W = $clog2(N_ROWS);
    localparam int DRAIN_CYC = RD_LAT + 1 + MAC_LAT;
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(DRAIN_CYC - 1);
    localparam logic [LEN_W-1:0] ROW_LAST = LEN_W'(N_ROWS - 1);

    state_t           state, state_d;
    logic [LEN_W-1:0] cnt, cnt_d;
    logic [LEN_W-1:0] len_q;
    logic             sub_q;
    logic             abort_clr;
    logic             done_q;
    logic             accept;
    logic             rd_ce, rd_csel;
    logic             d_ce, d_csel;

    // The done cycle already shows IDLE, but a start there must still be ignored.
    assign accept = (state == IDLE) && start && !done_q && !abort;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            sub_q     <= 1'b0;
            abort_clr <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            abort_clr <= abort;
            done_q    <= (state == OUT) && (cnt == ROW_LAST) && !abort;
            if (accept) begin
                len_q <= (cfg_len > MAX_LEN_V) ? MAX_LEN_V : cfg_len;
                sub_q <= cfg_sub;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        busy      = (state != IDLE);
        buf_rd_en = 1'b0;
        buf_addr  = '0;
        rd_ce     = 1'b0;
        rd_csel   = 1'b0;
        res_valid = 1'b0;
        res_sel   = '0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (accept) state_d = CLR;
            end
            CLR: begin
                cnt_d   = '0;
                state_d = (len_q == '0) ? OUT : STREAM;
            end
            STREAM: begin
                buf_rd_en = 1'b1;
                buf_addr  = cnt[LEN_W-2:0];
                rd_ce     = 1'b1;
                rd_csel   = (cnt != '0);
                if (cnt == len_q - LEN_W'(1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + LEN_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_d = OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + LEN_W'(1);
                end
            end
            OUT: begin
                res_valid = 1'b1;
                res_sel   = cnt[SEL_W-1:0];
                if (cnt == ROW_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + LEN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // Past the last aligned beat, DRAIN keeps csel high so the pipeline folds in rather than restarts.
        node_sclr = (state == CLR) || abort_clr;
        node_ce   = node_sclr || d_ce || (state == DRAIN);
        node_csel = d_ce ? d_csel : (state == DRAIN);
        node_sub  = busy && sub_q;
        done      = done_q;
    end

    mv_ctl_delay #(
        .DEPTH (RD_LAT + 1),
        .WIDTH (2)
    ) u_ctl_delay (
        .clk   (clk),
        .rstn  (rstn),
        .flush (abort),
        .din   ({rd_ce, rd_csel}),
        .dout  ({d_ce, d_csel})
    );

endmodule

// File: tb/tb_mv_seq_ctrl.sv
// Directed bench for mv_seq_ctrl: a small buffer/node model turns the control
// stream into dot-product results that are compared with hand-computed values.
module tb_mv_seq_ctrl;

    localparam int N_ROWS = 16;
    localparam int LEN_W  = 9;

    // Fixed-point scales: vec 1.0 = 2^17, mat 1.0 = 2^16, result 1.0 = 2^16.
    localparam logic signed [24:0] VEC_HALF = 25'sd65536;
    localparam logic signed [24:0] VEC_ONE  = 25'sd131072;
    localparam logic signed [24:0] VEC_TWO  = 25'sd262144;
    localparam logic signed [17:0] MAT_ONE  = 18'sd65536;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_sub = 1'b0;
    logic             busy, done, buf_rd_en, node_ce, node_sclr, node_csel, node_sub, res_valid;
    logic [LEN_W-2:0] buf_addr;
    logic [3:0]       res_sel;
    logic [19:0]      outs;

    assign outs = {busy, done, buf_rd_en, buf_addr, node_ce, node_sclr, node_csel, node_sub, res_sel, res_valid};

    always #5 clk = ~clk;

    mv_seq_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .cfg_sub   (cfg_sub),
        .busy      (busy),
        .done      (done),
        .buf_rd_en (buf_rd_en),
        .buf_addr  (buf_addr),
        .node_ce   (node_ce),
        .node_sclr (node_sclr),
        .node_csel (node_csel),
        .node_sub  (node_sub),
        .res_sel   (res_sel),
        .res_valid (res_valid)
    );

    int checks = 0;
    int failures = 0;

    logic signed [24:0] vec_val = '0;
    logic signed [17:0] mat_val = '0;
    logic signed [24:0] buf_a, in_a;
    logic signed [17:0] buf_b, in_b;
    logic signed [47:0] acc, prod;
    bit                 beat_q, beat_in;
    int                 done_cnt, rd_cnt, sclr_cnt, sub_low, ce_miss;
    bit                 csel_log[$];
    int                 addr_log[$];
    logic [24:0]        res_log[$];
    int                 sel_log[$];

    // Buffers answer one cycle after rd_en, nodes register that data one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                acc = '0; buf_a = '0; buf_b = '0; in_a = '0; in_b = '0;
                beat_q = 1'b0; beat_in = 1'b0;
            end else begin
                if (node_ce) begin
                    if (node_sclr) begin
                        acc = '0;
                    end else begin
                        prod = in_a * in_b;
                        if (node_sub) prod = -prod;
                        acc = node_csel ? acc + prod : prod;
                    end
                end
                if (beat_in) begin
                    csel_log.push_back(node_csel);
                    if (!node_ce) ce_miss++;
                end
                beat_in = beat_q;
                beat_q  = buf_rd_en;
                in_a    = buf_a;
                in_b    = buf_b;
                buf_a   = buf_rd_en ? vec_val : 25'sd0;
                buf_b   = buf_rd_en ? mat_val : 18'sd0;
                if (done) done_cnt++;
                if (buf_rd_en) begin
                    rd_cnt++;
                    addr_log.push_back(int'(buf_addr));
                end
                if (node_sclr) sclr_cnt++;
                if (busy && !node_sub) sub_low++;
                if (res_valid) begin
                    res_log.push_back({acc[47], acc[40:17]});
                    sel_log.push_back(int'(res_sel));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        done_cnt = 0; rd_cnt = 0; sclr_cnt = 0; sub_low = 0; ce_miss = 0;
        csel_log.delete(); addr_log.delete(); res_log.delete(); sel_log.delete();
    endtask

    // Pulses start and returns the number of cycles until done, or -1 on timeout.
    task automatic run_job(input int len, input bit sub, output int lat);
        bit seen = 1'b0;
        @(negedge clk);
        cfg_len = LEN_W'(len);
        cfg_sub = sub;
        start = 1'b1;
        lat = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) lat = -1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (outs !== 20'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (outs !== 20'd0) begin failures++; $display("FAIL idle_outputs got=%h exp=0", outs); end
    endtask

    task automatic test_basic();
        int lat;
        bit exp_csel[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        clear_logs();
        vec_val = VEC_ONE; mat_val = MAT_ONE;
        run_job(4, 1'b0, lat);
        checks++; if (lat !== 27) begin failures++; $display("FAIL basic_latency got=%0d exp=27", lat); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
        checks++; if (rd_cnt !== 4) begin failures++; $display("FAIL basic_reads got=%0d exp=4", rd_cnt); end
        checks++; if (ce_miss !== 0) begin failures++; $display("FAIL basic_ce_alignment got=%0d exp=0", ce_miss); end
        checks++; if (csel_log.size() !== 4) begin failures++; $display("FAIL basic_csel_beats got=%0d exp=4", csel_log.size()); end
        for (int k = 0; k < 4 && k < csel_log.size(); k++) begin
            checks++; if (csel_log[k] !== exp_csel[k]) begin failures++; $display("FAIL basic_csel[%0d] got=%0d exp=%0d", k, csel_log[k], exp_csel[k]); end
            checks++; if (addr_log[k] !== k) begin failures++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", k, addr_log[k], k); end
        end
        checks++; if (res_log.size() !== N_ROWS) begin failures++; $display("FAIL basic_beats got=%0d exp=%0d", res_log.size(), N_ROWS); end
        for (int r = 0; r < res_log.size(); r++) begin
            checks++; if (res_log[r] !== 25'h0040000) begin failures++; $display("FAIL basic_res[%0d] got=%h exp=0040000", r, res_log[r]); end
            checks++; if (sel_log[r] !== r) begin failures++; $display("FAIL basic_sel[%0d] got=%0d exp=%0d", r, sel_log[r], r); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_subtract();
        int lat;
        clear_logs();
        vec_val = VEC_TWO; mat_val = MAT_ONE;
        run_job(3, 1'b1, lat);
        checks++; if (lat !== 26) begin failures++; $display("FAIL sub_latency got=%0d exp=26", lat); end
        checks++; if (sub_low !== 0) begin failures++; $display("FAIL sub_held busy_cycles_low=%0d exp=0", sub_low); end
        checks++; if (res_log.size() !== N_ROWS) begin failures++; $display("FAIL sub_beats got=%0d exp=%0d", res_log.size(), N_ROWS); end
        for (int r = 0; r < res_log.size(); r++) begin
            checks++; if (res_log[r] !== 25'h1FA0000) begin failures++; $display("FAIL sub_res[%0d] got=%h exp=1fa0000", r, res_log[r]); end
        end
        checks++; if (node_sub !== 1'b0) begin failures++; $display("FAIL sub_idle got=%b exp=0", node_sub); end
    endtask

    task automatic test_zero_len();
        int lat;
        clear_logs();
        vec_val = VEC_ONE; mat_val = MAT_ONE;
        run_job(0, 1'b0, lat);
        checks++; if (lat !== 18) begin failures++; $display("FAIL zero_latency got=%0d exp=18", lat); end
        checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL zero_reads got=%0d exp=0", rd_cnt); end
        checks++; if (sclr_cnt !== 1) begin failures++; $display("FAIL zero_sclr got=%0d exp=1", sclr_cnt); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        checks++; if (res_log.size() !== N_ROWS) begin failures++; $display("FAIL zero_beats got=%0d exp=%0d", res_log.size(), N_ROWS); end
        for (int r = 0; r < res_log.size(); r++) begin
            checks++; if (res_log[r] !== 25'h0) begin failures++; $display("FAIL zero_res[%0d] got=%h exp=0", r, res_log[r]); end
        end
    endtask

    task automatic test_clamp();
        int lat;
        int bad = 0;
        clear_logs();
        vec_val = VEC_HALF; mat_val = MAT_ONE;
        run_job(300, 1'b0, lat);
        checks++; if (lat !== 279) begin failures++; $display("FAIL clamp_latency got=%0d exp=279", lat); end
        checks++; if (rd_cnt !== 256) begin failures++; $display("FAIL clamp_reads got=%0d exp=256", rd_cnt); end
        for (int k = 0; k < addr_log.size(); k++) if (addr_log[k] != k) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL clamp_addr_sequence bad=%0d exp=0", bad); end
        checks++; if (res_log.size() !== N_ROWS) begin failures++; $display("FAIL clamp_beats got=%0d exp=%0d", res_log.size(), N_ROWS); end
        if (res_log.size() > 0) begin
            checks++; if (res_log[0] !== 25'h0800000) begin failures++; $display("FAIL clamp_res got=%h exp=0800000", res_log[0]); end
        end
    endtask

    task automatic test_abort();
        int lat;
        bit found = 1'b0;
        clear_logs();
        vec_val = VEC_ONE; mat_val = MAT_ONE;
        @(negedge clk);
        cfg_len = 9'd8; cfg_sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (buf_rd_en && buf_addr == 8'd2) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL abort_reach_k2 got=%b exp=1", found); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, node_sclr, node_ce} !== 3'b011) begin failures++; $display("FAIL abort_exit_clear got=%b exp=011", {busy, node_sclr, node_ce}); end
        @(negedge clk);
        checks++; if ({busy, node_sclr, node_ce} !== 3'b000) begin failures++; $display("FAIL abort_single_clear got=%b exp=000", {busy, node_sclr, node_ce}); end
        repeat (40) @(negedge clk);
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        checks++; if (rd_cnt !== 3) begin failures++; $display("FAIL abort_reads got=%0d exp=3", rd_cnt); end
        clear_logs();
        run_job(2, 1'b0, lat);
        checks++; if (lat !== 25) begin failures++; $display("FAIL abort_next_latency got=%0d exp=25", lat); end
        checks++; if (res_log.size() !== N_ROWS) begin failures++; $display("FAIL abort_next_beats got=%0d exp=%0d", res_log.size(), N_ROWS); end
        for (int r = 0; r < res_log.size(); r++) begin
            checks++; if (res_log[r] !== 25'h0020000) begin failures++; $display("FAIL abort_next_res[%0d] got=%h exp=0020000", r, res_log[r]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        clear_logs();
        vec_val = VEC_ONE; mat_val = MAT_ONE;
        @(negedge clk);
        cfg_len = 9'd4; cfg_sub = 1'b1; start = 1'b1;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if ({busy, node_ce, buf_rd_en, res_valid} !== 4'b1100) begin failures++; $display("FAIL rstmid_in_drain got=%b exp=1100", {busy, node_ce, buf_rd_en, res_valid}); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (outs !== 20'd0) begin failures++; $display("FAIL rstmid_async_outputs got=%h exp=0", outs); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
        clear_logs();
        run_job(1, 1'b0, lat);
        checks++; if (lat !== 24) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=24", lat); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rstmid_next_done got=%0d exp=1", done_cnt); end
        for (int r = 0; r < res_log.size(); r++) begin
            checks++; if (res_log[r] !== 25'h0010000) begin failures++; $display("FAIL rstmid_next_res[%0d] got=%h exp=0010000", r, res_log[r]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        int lat2;
        bit seen = 1'b0;
        clear_logs();
        vec_val = VEC_ONE; mat_val = MAT_ONE;
        @(negedge clk);
        cfg_len = 9'd1; cfg_sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (lat == 3) start = 1'b1;
        end
        if (!seen) lat = -1;
        cfg_len = 9'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (lat !== 24) begin failures++; $display("FAIL b2b_busy_start_latency got=%0d exp=24", lat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_start_on_done got=%b exp=0", busy); end
        repeat (30) @(negedge clk);
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt); end
        run_job(0, 1'b0, lat2);
        checks++; if (lat2 !== 18) begin failures++; $display("FAIL b2b_next_latency got=%0d exp=18", lat2); end
        checks++; if (done_cnt !== 2) begin failures++; $display("FAIL b2b_total_done got=%0d exp=2", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_subtract();
        test_zero_len();
        test_clamp();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
